// File: rtl/sfa_pkg.sv
// sfa_pkg: shared SFA tile types for the input and output switches
package sfa_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {DIR_N = 2'd0, DIR_E = 2'd1, DIR_S = 2'd2, DIR_W = 2'd3} sfa_dir_t;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} sw_state_t;
endpackage

// File: rtl/sfa_axis_skid.sv
// sfa_axis_skid: 2-entry head/skid buffer with registered ready and a stall that blocks new accepts
module sfa_axis_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  output logic         s_ready,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic         empty_next
);
  logic         skid_v, head_n_v, skid_n_v, pop, acc;
  logic [W-1:0] skid_d, head_n_d, skid_n_d;
  always_comb begin
    pop = m_valid && m_ready;
    acc = s_valid && s_ready;
    head_n_v = m_valid;
    head_n_d = m_data;
    skid_n_v = skid_v;
    skid_n_d = skid_d;
    if (pop) begin
      head_n_v = skid_v || acc;
      head_n_d = skid_v ? skid_d : s_data;
      skid_n_v = 1'b0;
    end else if (acc && m_valid) begin
      skid_n_v = 1'b1;
      skid_n_d = s_data;
    end else if (acc) begin
      head_n_v = 1'b1;
      head_n_d = s_data;
    end
    empty_next = !head_n_v && !skid_n_v;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid <= 1'b0;
      skid_v  <= 1'b0;
      s_ready <= 1'b0;
      m_data  <= '0;
      skid_d  <= '0;
    end else begin
      m_valid <= head_n_v;
      skid_v  <= skid_n_v;
      s_ready <= !skid_n_v && !stall;
      m_data  <= head_n_d;
      skid_d  <= skid_n_d;
    end
endmodule

// File: rtl/sfa_out_switch.sv
// sfa_out_switch: fans one AXI-Stream out to N/E/S/W; direction changes wait for the buffer to drain
module sfa_out_switch #(
  parameter int DATA_W = sfa_pkg::DATA_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [1:0]        CONF,
  output logic              si_tready,
  input  logic              si_tvalid,
  input  logic [DATA_W-1:0] si_tdata,
  input  logic              mn_tready,
  input  logic              me_tready,
  input  logic              ms_tready,
  input  logic              mw_tready,
  output logic              mn_tvalid,
  output logic              me_tvalid,
  output logic              ms_tvalid,
  output logic              mw_tvalid,
  output logic [DATA_W-1:0] mn_tdata,
  output logic [DATA_W-1:0] me_tdata,
  output logic [DATA_W-1:0] ms_tdata,
  output logic [DATA_W-1:0] mw_tdata
);
  import sfa_pkg::*;
  sw_state_t         state_q, state_n;
  sfa_dir_t          conf_q, conf_n;
  logic              head_v, empty_next;
  logic [3:0]        m_ready;
  logic [DATA_W-1:0] head_d;
  assign m_ready = {mw_tready, ms_tready, me_tready, mn_tready};
  sfa_axis_skid #(.W(DATA_W)) u_skid (
    .clk       (ACLK),
    .rst       (ARESET),
    .stall     (state_n == DRAIN),
    .s_ready   (si_tready),
    .s_valid   (si_tvalid),
    .s_data    (si_tdata),
    .m_valid   (head_v),
    .m_data    (head_d),
    .m_ready   (m_ready[conf_q]),
    .empty_next(empty_next)
  );
  assign mn_tvalid = head_v && conf_q == DIR_N;
  assign me_tvalid = head_v && conf_q == DIR_E;
  assign ms_tvalid = head_v && conf_q == DIR_S;
  assign mw_tvalid = head_v && conf_q == DIR_W;
  assign mn_tdata  = head_d;
  assign me_tdata  = head_d;
  assign ms_tdata  = head_d;
  assign mw_tdata  = head_d;
  // conf_q only moves once nothing accepted under the old direction remains
  always_comb begin
    state_n = state_q;
    conf_n  = conf_q;
    if (state_q == RUN) state_n = (sfa_dir_t'(CONF) != conf_q) ? DRAIN : RUN;
    else if (empty_next) begin
      state_n = RUN;
      conf_n  = sfa_dir_t'(CONF);
    end
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state_q <= RUN;
      conf_q  <= DIR_N;
    end else begin
      state_q <= state_n;
      conf_q  <= conf_n;
    end
endmodule
